ex_mem_pipe_stage: RTL and testbench
====================================

Name: ex_mem_pipe_stage

Overview:
Parametrised EX/MEM pipeline stage for the 5-stage RV64 core. It replaces a fixed always-load register with a valid/ready handshake stage. A 2-entry skid buffer gives full throughput with a registered in_ready. It supports synchronous flush for branch mispredict and traps, and masks the control bits of bubbles. It sits between the EX ALU/branch-adder outputs and the MEM data-memory interface.

Parameters:
DATA_W, 64, width of ALU result, store data and branch target.
RD_W, 5, destination register index width.
CNT_W, 16, width of the stall/bubble performance counters.

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept; registered, equals "skid entry empty"
in_rd  in  RD_W  destination register
in_read_data2  in  DATA_W  store data (rs2)
in_alu_result  in  DATA_W  ALU result / memory address
in_zero  in  1  ALU zero flag
in_pc_out  in  DATA_W  branch target
in_ctrl  in  5  {branch, mem_read, mem_write, reg_write, mem_to_reg}
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM accepts this cycle
out_rd, out_read_data2, out_alu_result, out_zero, out_pc_out  out  as inputs  registered payload
out_ctrl  out  5  registered control bits; forced 0 when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  out  CNT_W  cycles with out_valid=0

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, in_ready=1, all payload and out_ctrl=0, both counters=0, state=EMPTY. On release, in_ready=1 from the first edge.
- Transfer in: in_valid & in_ready at an edge. Transfer out: out_valid & out_ready at an edge.
- Storage: main register (drives outputs) plus one skid register.
- States:
  - EMPTY: main invalid, skid empty.
  - BUSY: main valid, skid empty.
  - FULL: main and skid valid.
- EMPTY: transfer in -> load main, go to BUSY. Latency input-to-output is 1 cycle.
- BUSY:
  - in and out together -> reload main, stay BUSY. This gives 1 instruction per cycle.
  - in only -> load skid, go to FULL.
  - out only -> go to EMPTY.
- FULL: in_ready=0, so no transfer in. Out -> skid moves to main, skid cleared, go to BUSY.
- in_ready is a register equal to (next state != FULL). It has no combinational path from out_ready.
- Flush at an edge (reset=1): next state EMPTY, out_valid=0, out_ctrl=0, skid cleared. A simultaneous incoming transfer is dropped. in_ready=1 on the next cycle. Flush takes priority over every transfer. Payload data fields may retain stale values.
- out_ctrl is masked to 0 whenever out_valid=0, so a bubble can never write the regfile or memory. Payload fields need not be masked.
- Payload registers load only on an accepted transfer; otherwise they hold. Output payload is stable while out_valid=1 and out_ready=0.
- Counters increment by 1 per qualifying cycle, saturate at all-ones (no wrap), and are not cleared by flush.
- in_valid while in_ready=0 is ignored. EX must hold its data, and the stage does not check this.

Decomposition:
- Shared package holds:
  - the index constants for the in_ctrl/out_ctrl bit positions (CTRL_BRANCH=4 down to CTRL_MEMTOREG=0) and CTRL_W=5;
  - the state encoding localparams EMPTY/BUSY/FULL.
- One natural sub-module, sat_counter (parameter CNT_W, ports clk/reset/inc/count). It is instantiated twice, for stall_cnt and bubble_cnt.

Test Plan:
1. Streaming: reset, out_ready=1, in_valid=1 for 8 cycles with alu_result=0x10..0x17, ctrl=5'b00110 -> out_valid from cycle 1, outputs 0x10..0x17 in order with no gaps; in_ready stays 1; stall_cnt=0.
2. Backpressure: 3 beats (0xA,0xB,0xC), out_ready=0 from cycle 1 -> state FULL after beat 2, in_ready=0, beat 0xC held at EX. Raise out_ready -> outputs 0xA,0xB,0xC in order, no loss or duplication; stall_cnt equals the number of stalled cycles.
3. Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1. The incoming beat never appears.
4. Bubble masking: in_valid=0 for 4 cycles after a beat with ctrl=5'b01011 -> out_ctrl=0 while out_valid=0; bubble_cnt +4.
5. Async reset mid-FULL: drive reset=0 between clock edges -> out_valid, out_ctrl and counters go to 0 without a clock edge. After release, the first new beat is output 1 cycle later.
6. Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/ex_mem_pipe_stage_pkg.sv
// Shared constants for the EX/MEM pipeline stage: control-bit positions and
// the handshake state encoding.
package ex_mem_pipe_stage_pkg;

  localparam int CTRL_W        = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ex_mem_pipe_stage_sat_counter.sv
// Saturating up-counter used for the stall and bubble performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and bubble control masking.
module ex_mem_pipe_stage
  import ex_mem_pipe_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_read_data2,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_pc_out,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_read_data2,
  output logic [DATA_W-1:0] out_alu_result,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_pc_out,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] pc_out;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  state_t   r_state;
  state_t   w_next_state;
  logic     r_in_ready;
  logic     r_out_valid;
  payload_t r_main;
  payload_t r_skid;
  payload_t w_in_payload;
  logic     w_in_fire;
  logic     w_out_fire;
  logic     w_load_main;
  logic     w_main_from_skid;
  logic     w_load_skid;

  assign w_in_payload = '{rd:         in_rd,
                          read_data2: in_read_data2,
                          alu_result: in_alu_result,
                          zero:       in_zero,
                          pc_out:     in_pc_out,
                          ctrl:       in_ctrl};

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    w_next_state     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next_state = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_next_state = BUSY;
            w_load_main  = 1'b1;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
          end else if (w_in_fire) begin
            w_next_state = FULL;
            w_load_skid  = 1'b1;
          end else if (w_out_fire) begin
            w_next_state = EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_next_state     = BUSY;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != FULL);
      r_out_valid <= (w_next_state != EMPTY);
      if (w_load_main) begin
        r_main <= w_in_payload;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      // NOTE: the later non-blocking assignment wins, so a stage going empty
      // always leaves its control bits cleared regardless of the load above.
      if (w_next_state == EMPTY) begin
        r_main.ctrl <= '0;
      end
      if (w_load_skid) begin
        r_skid <= w_in_payload;
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_rd         = r_main.rd;
  assign out_read_data2 = r_main.read_data2;
  assign out_alu_result = r_main.alu_result;
  assign out_zero       = r_main.zero;
  assign out_pc_out     = r_main.pc_out;
  assign out_ctrl       = r_main.ctrl;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (r_out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~r_out_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: directed stimulus pushes accepted
// beats, a negedge monitor pops and compares every delivered beat.
module tb_ex_mem_pipe_stage;
  import ex_mem_pipe_stage_pkg::*;

  localparam int DATA_W = 64;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] pc_out;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [RD_W-1:0]   in_rd = '0;
  logic [DATA_W-1:0] in_read_data2 = '0;
  logic [DATA_W-1:0] in_alu_result = '0;
  logic              in_zero = 1'b0;
  logic [DATA_W-1:0] in_pc_out = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;

  logic              in_ready;
  logic              out_valid;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_read_data2;
  logic [DATA_W-1:0] out_alu_result;
  logic              out_zero;
  logic [DATA_W-1:0] out_pc_out;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [RD_W-1:0]   s_out_rd;
  logic [DATA_W-1:0] s_out_read_data2;
  logic [DATA_W-1:0] s_out_alu_result;
  logic              s_out_zero;
  logic [DATA_W-1:0] s_out_pc_out;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [SAT_W-1:0]  s_stall_cnt;
  logic [SAT_W-1:0]  s_bubble_cnt;

  always #5 clk = ~clk;

  ex_mem_pipe_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rd          (in_rd),
    .in_read_data2  (in_read_data2),
    .in_alu_result  (in_alu_result),
    .in_zero        (in_zero),
    .in_pc_out      (in_pc_out),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rd         (out_rd),
    .out_read_data2 (out_read_data2),
    .out_alu_result (out_alu_result),
    .out_zero       (out_zero),
    .out_pc_out     (out_pc_out),
    .out_ctrl       (out_ctrl),
    .stall_cnt      (stall_cnt),
    .bubble_cnt     (bubble_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  ex_mem_pipe_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(SAT_W)) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (s_in_ready),
    .in_rd          (in_rd),
    .in_read_data2  (in_read_data2),
    .in_alu_result  (in_alu_result),
    .in_zero        (in_zero),
    .in_pc_out      (in_pc_out),
    .in_ctrl        (in_ctrl),
    .out_valid      (s_out_valid),
    .out_ready      (out_ready),
    .out_rd         (s_out_rd),
    .out_read_data2 (s_out_read_data2),
    .out_alu_result (s_out_alu_result),
    .out_zero       (s_out_zero),
    .out_pc_out     (s_out_pc_out),
    .out_ctrl       (s_out_ctrl),
    .stall_cnt      (s_stall_cnt),
    .bubble_cnt     (s_bubble_cnt)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t sb_q[$];
  beat_t in_beat;
  beat_t out_beat;
  beat_t mon_exp;

  assign in_beat  = {in_rd, in_read_data2, in_alu_result, in_zero, in_pc_out, in_ctrl};
  assign out_beat = {out_rd, out_read_data2, out_alu_result, out_zero, out_pc_out, out_ctrl};

  function automatic beat_t make_beat(input logic [DATA_W-1:0] a, input logic [CTRL_W-1:0] c);
    beat_t b;
    b.rd         = a[RD_W-1:0] ^ 5'h15;
    b.read_data2 = ~a;
    b.alu_result = a;
    b.zero       = a[0];
    b.pc_out     = (a << 2) + 64'h8000;
    b.ctrl       = c;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_rd         = b.rd;
    in_read_data2 = b.read_data2;
    in_alu_result = b.alu_result;
    in_zero       = b.zero;
    in_pc_out     = b.pc_out;
    in_ctrl       = b.ctrl;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: inputs are stable at the falling edge, so a handshake seen here
  // is the one the next rising edge will commit.
  always @(negedge clk) begin
    if (!reset || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_beat: got alu 0x%0h, expected no beat", out_alu_result);
        end else begin
          mon_exp = sb_q.pop_front();
          if (out_beat === mon_exp) n_pass++;
          else $display("FAIL beat: got %h, expected %h", out_beat, mon_exp);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_beat);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: streaming at one beat per cycle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(make_beat(64'h10 + 64'(i), 5'b00110));
      in_valid = 1'b1;
      check("t1_in_ready", in_ready, 1);
      if (i > 0) begin
        check("t1_no_gap", out_valid, 1);
        check("t1_alu", out_alu_result, 64'h10 + 64'(i - 1));
      end
      step();
    end
    in_valid = 1'b0;
    check("t1_last_alu", out_alu_result, 64'h17);
    step();
    check("t1_drained", out_valid, 0);
    check("t1_stall", stall_cnt, 0);
    check("t1_bubble", bubble_cnt, 1);

    // 2: backpressure fills the skid entry
    do_reset();
    drive(make_beat(64'hA, 5'b10100));
    in_valid = 1'b1;
    step();
    check("t2_ready_busy", in_ready, 1);
    drive(make_beat(64'hB, 5'b10100));
    step();
    check("t2_ready_full", in_ready, 0);
    check("t2_valid", out_valid, 1);
    check("t2_alu_a", out_alu_result, 64'hA);
    drive(make_beat(64'hC, 5'b10100));
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_ready_held", in_ready, 0);
      check("t2_alu_held", out_alu_result, 64'hA);
    end
    check("t2_stall", stall_cnt, 4);
    out_ready = 1'b1;
    step();
    check("t2_ready_reopen", in_ready, 1);
    check("t2_alu_b", out_alu_result, 64'hB);
    step();
    in_valid = 1'b0;
    check("t2_alu_c", out_alu_result, 64'hC);
    step();
    check("t2_drained", out_valid, 0);
    check("t2_stall_final", stall_cnt, 4);
    check("t2_bubble", bubble_cnt, 1);

    // 3: flush in FULL, then flush racing an accepted beat in BUSY
    do_reset();
    drive(make_beat(64'h20, 5'b11111));
    in_valid = 1'b1;
    step();
    drive(make_beat(64'h21, 5'b11111));
    step();
    check("t3_full", in_ready, 0);
    drive(make_beat(64'h22, 5'b11111));
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t3_valid_flushed", out_valid, 0);
    check("t3_ctrl_flushed", out_ctrl, 0);
    check("t3_ready_flushed", in_ready, 1);
    drive(make_beat(64'h23, 5'b11111));
    in_valid = 1'b1;
    step();
    check("t3_busy_ctrl", out_ctrl, 5'b11111);
    drive(make_beat(64'h24, 5'b11111));
    flush = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t3_valid_drop", out_valid, 0);
    check("t3_ctrl_drop", out_ctrl, 0);
    check("t3_ready_drop", in_ready, 1);
    step();
    check("t3_no_ghost", out_valid, 0);
    drive(make_beat(64'h25, 5'b00010));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t3_recover_alu", out_alu_result, 64'h25);
    step();
    check("t3_recover_drain", out_valid, 0);

    // 4: bubbles carry no control bits
    do_reset();
    out_ready = 1'b1;
    drive(make_beat(64'h30, 5'b01011));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t4_valid", out_valid, 1);
    check("t4_ctrl", out_ctrl, 5'b01011);
    check("t4_bubble_start", bubble_cnt, 1);
    step();
    for (int k = 0; k < 4; k++) begin
      check("t4_bubble_valid", out_valid, 0);
      check("t4_bubble_ctrl", out_ctrl, 0);
      step();
    end
    check("t4_bubble_cnt", bubble_cnt, 5);

    // 5: asynchronous reset while FULL
    do_reset();
    drive(make_beat(64'h40, 5'b01100));
    in_valid = 1'b1;
    step();
    drive(make_beat(64'h41, 5'b01100));
    step();
    in_valid = 1'b0;
    step();
    check("t5_pre_valid", out_valid, 1);
    check("t5_pre_stall", stall_cnt, 2);
    #1;
    reset = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_ctrl", out_ctrl, 0);
    check("t5_async_stall", stall_cnt, 0);
    check("t5_async_bubble", bubble_cnt, 0);
    check("t5_async_ready", in_ready, 1);
    check("t5_async_sat_stall", s_stall_cnt, 0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(make_beat(64'h42, 5'b00011));
    in_valid = 1'b1;
    check("t5_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t5_first_valid", out_valid, 1);
    check("t5_first_alu", out_alu_result, 64'h42);
    step();
    check("t5_drained", out_valid, 0);

    // 6: stall counter saturation on the narrow copy
    do_reset();
    drive(make_beat(64'h50, 5'b00110));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("t6_sat_stall", s_stall_cnt, (k > 15) ? 15 : k);
      check("t6_wide_stall", stall_cnt, k);
    end
    check("t6_sat_bubble", s_bubble_cnt, 1);
    out_ready = 1'b1;
    step();
    step();
    check("t6_drained", out_valid, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
